// File: rtl/maj_voter_seq_if.sv
// Bus interface for maj_voter_seq: vote request, clear strobe and voted results.
// The master side drives the votes and the voter (slave) returns its results.
interface maj_voter_seq_if #(
  parameter int N = 3,
  parameter int W = 8
);
  logic           in_valid;
  logic [N*W-1:0] in_data;
  logic           clr_fault;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           mismatch;
  logic [N-1:0]   fault_mask;

  modport master (
    output in_valid, in_data, clr_fault,
    input  out_valid, out_data, mismatch, fault_mask
  );

  modport slave (
    input  in_valid, in_data, clr_fault,
    output out_valid, out_data, mismatch, fault_mask
  );
endinterface

// File: rtl/maj_voter_seq.sv
// Registered N-channel bitwise majority voter with per-channel health tracking.
// Each channel runs an OK/SUSPECT/FAULTED FSM driven by disagreement with the
// voted word; FAULTED is sticky until clr_fault or rst.
// Optional build macro MAJ_EXCLUDE_FAULTED_EN: faulted channels are dropped
// from the vote and the threshold follows the number of remaining channels.
module maj_voter_seq #(
  parameter int N           = 3,
  parameter int W           = 8,
  parameter int THRESH      = (N / 2) + 1,
  parameter int FAULT_LIMIT = 3
) (
  input logic          clk,
  input logic          rst,
  maj_voter_seq_if.slave bus
);
  localparam int OW = $clog2(N + 1);
  localparam int CW = $clog2(FAULT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(FAULT_LIMIT);
  localparam logic [OW-1:0] THRESH_C = OW'(THRESH);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULTED} state_t;

  state_t        state_reg  [N];
  state_t        state_next [N];
  logic [CW-1:0] cnt_reg    [N];
  logic [CW-1:0] cnt_next   [N];

  logic          out_valid_reg;
  logic [W-1:0]  out_data_reg;
  logic          mismatch_reg;

  logic [W-1:0]  chan [N];
  logic [N-1:0]  fault_mask_int;
  logic [N-1:0]  vote_en;
  logic [OW-1:0] thresh_eff;
  logic          any_active;
  logic [W-1:0]  voted_raw;
  logic [W-1:0]  voted;
  logic [N-1:0]  disagree;
  logic          mismatch_next;

  genvar gi;

  // Split the packed input bus into channel words and expose the FAULTED flags.
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan[gi]           = bus.in_data[gi*W +: W];
      assign fault_mask_int[gi] = (state_reg[gi] == ST_FAULTED);
    end
  endgenerate

`ifdef MAJ_EXCLUDE_FAULTED_EN
  logic [OW-1:0] active_cnt;

  // Only healthy channels vote; threshold is a strict majority of those.
  always_comb begin
    vote_en    = ~fault_mask_int;
    active_cnt = '0;
    for (int c = 0; c < N; c++) begin
      active_cnt = active_cnt + OW'(vote_en[c]);
    end
    thresh_eff = (active_cnt >> 1) + OW'(1);
    any_active = (active_cnt != '0);
  end
`else
  // Every channel always votes against the fixed threshold.
  assign vote_en    = '1;
  assign thresh_eff = THRESH_C;
  assign any_active = 1'b1;
`endif

  // Per-bit ones count across participating channels, compared to threshold.
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic [OW-1:0] ones;
      always_comb begin
        ones = '0;
        for (int c = 0; c < N; c++) begin
          ones = ones + OW'(chan[c][gi] & vote_en[c]);
        end
        voted_raw[gi] = (ones >= thresh_eff);
      end
    end
  endgenerate

  // With no healthy channel left the previous result is simply repeated.
  assign voted = any_active ? voted_raw : out_data_reg;

  // Every channel is compared for health tracking; mismatch only reflects voters.
  generate
    for (gi = 0; gi < N; gi++) begin : g_dis
      assign disagree[gi] = (chan[gi] != voted);
    end
  endgenerate

  assign mismatch_next = any_active ? |(disagree & vote_en) : 1'b1;

  // Channel health next-state: clr_fault first clears, then an accepted vote
  // is applied on top of the (possibly cleared) state.
  always_comb begin
    state_t        st;
    logic [CW-1:0] ct;
    st = ST_OK;
    ct = '0;
    for (int i = 0; i < N; i++) begin
      st            = bus.clr_fault ? ST_OK : state_reg[i];
      ct            = bus.clr_fault ? '0    : cnt_reg[i];
      state_next[i] = st;
      cnt_next[i]   = ct;
      if (bus.in_valid) begin
        case (st)
          ST_OK: begin
            if (disagree[i]) begin
              cnt_next[i]   = CW'(1);
              state_next[i] = (LIMIT == CW'(1)) ? ST_FAULTED : ST_SUSPECT;
            end else begin
              cnt_next[i]   = '0;
            end
          end
          ST_SUSPECT: begin
            if (disagree[i]) begin
              // ct < LIMIT here, so the increment cannot wrap.
              cnt_next[i] = ct + CW'(1);
              if ((ct + CW'(1)) >= LIMIT) state_next[i] = ST_FAULTED;
            end else begin
              cnt_next[i]   = '0;
              state_next[i] = ST_OK;
            end
          end
          ST_FAULTED: begin
            state_next[i] = ST_FAULTED;
          end
          default: begin
            state_next[i] = ST_OK;
            cnt_next[i]   = '0;
          end
        endcase
      end
    end
  end

  // State and result registers; result fields hold when no vote is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      mismatch_reg  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        state_reg[i] <= ST_OK;
        cnt_reg[i]   <= '0;
      end
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        out_data_reg <= voted;
        mismatch_reg <= mismatch_next;
      end
      for (int i = 0; i < N; i++) begin
        state_reg[i] <= state_next[i];
        cnt_reg[i]   <= cnt_next[i];
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.mismatch   = mismatch_reg;
  assign bus.fault_mask = fault_mask_int;
endmodule

// File: doc/maj_voter_seq.md
Name: maj_voter_seq

Overview:
- Parametrised, registered N-channel bitwise majority voter; generalises the 3-input majority function Y = AB + BC + CA to N channels of W-bit words.
- Adds per-channel disagreement tracking: a per-channel health FSM and a sticky fault mask.
- Sits between redundant datapath replicas and downstream logic; a fault mask feeds system monitoring.

Parameters:
- N, 3, number of voting channels; odd, ≥3.
- W, 8, width of each channel word.
- THRESH, (N/2)+1, minimum count of 1s among N channels for an output bit to be 1.
- FAULT_LIMIT, 3, consecutive disagreeing votes before a channel is declared faulted; ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  vote request; in_data is sampled when high.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- clr_fault  input  1  clears all counters, channel states and fault_mask.
- out_valid  output  1  one-cycle pulse, one cycle after an accepted vote.
- out_data  output  W  voted word; holds its value between votes.
- mismatch  output  1  high with out_valid when any channel disagreed with the voted word.
- fault_mask  output  N  bit i high = channel i FAULTED (sticky).

Behaviour:
- Reset (rst=1 at a clk edge) forces out_valid=0, out_data=0, mismatch=0, fault_mask=0, all counters=0, all channel FSMs=OK. Reset mid-vote discards that vote; there is no out_valid pulse for it.
- Vote, per bit b: ones[b] = number of channels with bit b set; voted[b] = (ones[b] ≥ THRESH). Use an unsigned adder of width clog2(N+1) with no overflow.
- Latency: in_valid at edge k gives out_valid=1 and out_data=voted after edge k, i.e. during cycle k+1. Back-to-back votes are accepted every cycle; there is no backpressure.
- in_valid=0: out_valid=0; out_data, mismatch and counters hold.
- Disagree_i = (channel i word ≠ voted word). mismatch = OR of all disagree_i, registered alongside out_data.
- Per-channel FSM, updated only on accepted votes:
  - OK: disagree → SUSPECT, cnt=1 (→ FAULTED directly if FAULT_LIMIT=1); agree → stay, cnt=0.
  - SUSPECT: disagree → cnt+1; when cnt reaches FAULT_LIMIT → FAULTED. Agree → OK, cnt=0.
  - FAULTED: sticky. cnt saturates at FAULT_LIMIT. Leaves only on clr_fault or rst.
- fault_mask[i] = (state_i == FAULTED), registered; it asserts in the same cycle as the out_valid of the vote that caused the fault.
- clr_fault: takes effect at the edge. It has priority over the FSM update; a vote in the same cycle is then evaluated from a cleared state (counter becomes 1 if it disagrees, else 0). The vote result itself is unaffected. rst has priority over clr_fault.
- Disagreement counter width: clog2(FAULT_LIMIT+1); it never wraps.

Optional Feature:
- Macro: MAJ_EXCLUDE_FAULTED_EN.
- Defined:
  - Channels with fault_mask[i]=1 are masked out of the vote (treated as absent, not as 0).
  - Effective threshold = floor(active/2)+1, where active = N − popcount(fault_mask); ties resolve to 0.
  - If active=0, out_data holds its previous value, out_valid still pulses, and mismatch=1.
  - Faulted channels still update no counters.
- Undefined: all N channels always vote with THRESH; fault_mask is informational only.

Test Plan:
- Defaults, rst held 2 cycles → out_valid=0, out_data=0x00, fault_mask=0; release, in_data={0xFF,0x0F,0xF0} (ch2,ch1,ch0) with in_valid=1 → next cycle out_valid=1, out_data=0xFF, mismatch=1.
- Exhaustive 3-bit check, W=1: all 8 patterns of {A,B,C} → out_data equals AB+BC+CA for each, one cycle after each vote, back-to-back.
- ch0=0x55, ch1=ch2=0xAA for 3 consecutive votes → fault_mask=3'b001 with the 3rd out_valid; a 4th vote with ch0 agreeing → fault_mask stays 3'b001.
- ch0 disagrees twice, agrees once, disagrees twice → fault_mask stays 0 (counter restarts).
- Faulted ch0, then clr_fault=1 with a same-cycle disagreeing vote → fault_mask=0 and ch0 counter=1; two more disagreements → fault_mask=3'b001.
- With MAJ_EXCLUDE_FAULTED_EN, N=5: ch0 and ch1 faulted, ch2=ch3=0x3C, ch4=0xC3, ch0=ch1=0xC3 → out_data=0x3C (active=3, threshold 2). Without the macro, the same stimulus gives out_data=0xC3.
